// File: rtl/mips_pkg.sv
// Shared definitions for the interrupt entry/return sequencer: state encoding,
// memory-stage selector codes and flag width.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH_LO,
        ST_PUSH_HI,
        ST_PUSH_FL,
        ST_VEC_LO,
        ST_VEC_HI,
        ST_JUMP,
        ST_R_DRAIN,
        ST_POP_FL,
        ST_POP_HI,
        ST_POP_LO,
        ST_RESTORE
    } int_state_t;

    // {sel1, sel2} codes driven to the memory stage
    localparam logic [1:0] SEL_PIPE = 2'b00;
    localparam logic [1:0] SEL_PUSH = 2'b10;
    localparam logic [1:0] SEL_POP  = 2'b01;
    localparam logic [1:0] SEL_VEC  = 2'b11;

    localparam int FLAG_W = 4;

endpackage

// File: rtl/int_drain_counter.sv
// Loadable down-counter with zero flag; times the pipeline drain before the
// controller takes over the memory stage. Saturates at zero.
module int_drain_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry / RTI sequencer: drains the pipeline, pushes or pops PC and
// flags through the memory stage, then redirects the PC.
module interrupt_controller
    import mips_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] VECTOR_ADDR  = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_req,
    input  logic              rti,
    input  logic [31:0]       pc_current,
    input  logic [FLAG_W-1:0] flags,
    input  logic [15:0]       mem_rdata,
    output logic              stall,
    output logic              if_flush,
    output logic              int_mem_selector1,
    output logic              int_mem_selector2,
    output logic [15:0]       int_wdata,
    output logic [15:0]       int_addr,
    output logic              pc_load,
    output logic [31:0]       pc_load_value,
    output logic              flags_load,
    output logic [FLAG_W-1:0] flags_restore,
    output logic              busy,
    output logic              int_ack
);

    localparam int               CNT_W          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD       = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [15:0]      VECTOR_ADDR_HI = VECTOR_ADDR + 16'd1;

    int_state_t        r_state;
    int_state_t        w_next_state;
    logic [31:0]       r_pc_hold;
    logic [FLAG_W-1:0] r_flags_hold;
    logic [15:0]       r_vec_lo;
    logic [15:0]       r_hi;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic [CNT_W-1:0]  w_cnt;
    logic [1:0]        w_sel;

    int_drain_counter #(.WIDTH(CNT_W)) u_drain_counter (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_cnt_load),
        .i_load_value (CNT_LOAD),
        .i_dec        (w_cnt_dec),
        .o_count      (w_cnt),
        .o_zero       (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Holding registers: interrupt context on entry, popped words on return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_hold    <= '0;
            r_flags_hold <= '0;
            r_vec_lo     <= '0;
            r_hi         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!rti && int_req) begin
                        r_pc_hold    <= pc_current;
                        r_flags_hold <= flags;
                    end
                end
                ST_VEC_HI: r_vec_lo     <= mem_rdata;
                ST_POP_HI: r_flags_hold <= mem_rdata[FLAG_W-1:0];
                ST_POP_LO: r_hi         <= mem_rdata;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        w_next_state  = r_state;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
        w_sel         = SEL_PIPE;
        int_wdata     = '0;
        int_addr      = '0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        flags_load    = 1'b0;
        flags_restore = '0;
        int_ack       = 1'b0;
        if_flush      = 1'b0;
        stall         = (r_state != ST_IDLE);
        busy          = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (rti) begin
                    w_next_state = ST_R_DRAIN;
                    w_cnt_load   = 1'b1;
                end else if (int_req) begin
                    w_next_state = ST_DRAIN;
                    w_cnt_load   = 1'b1;
                end
            end
            ST_DRAIN, ST_R_DRAIN: begin
                if_flush  = (w_cnt == CNT_LOAD);
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_next_state = (r_state == ST_DRAIN) ? ST_PUSH_LO : ST_POP_FL;
                end
            end
            ST_PUSH_LO: begin
                w_sel        = SEL_PUSH;
                int_wdata    = r_pc_hold[15:0];
                w_next_state = ST_PUSH_HI;
            end
            ST_PUSH_HI: begin
                w_sel        = SEL_PUSH;
                int_wdata    = r_pc_hold[31:16];
                w_next_state = ST_PUSH_FL;
            end
            ST_PUSH_FL: begin
                w_sel        = SEL_PUSH;
                int_wdata    = {{(16-FLAG_W){1'b0}}, r_flags_hold};
                w_next_state = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                w_sel        = SEL_VEC;
                int_addr     = VECTOR_ADDR;
                w_next_state = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                w_sel        = SEL_VEC;
                int_addr     = VECTOR_ADDR_HI;
                w_next_state = ST_JUMP;
            end
            ST_JUMP: begin
                pc_load       = 1'b1;
                pc_load_value = {mem_rdata, r_vec_lo};
                int_ack       = 1'b1;
                if_flush      = 1'b1;
                w_next_state  = ST_IDLE;
            end
            ST_POP_FL: begin
                w_sel        = SEL_POP;
                w_next_state = ST_POP_HI;
            end
            ST_POP_HI: begin
                w_sel        = SEL_POP;
                w_next_state = ST_POP_LO;
            end
            ST_POP_LO: begin
                w_sel        = SEL_POP;
                w_next_state = ST_RESTORE;
            end
            ST_RESTORE: begin
                pc_load       = 1'b1;
                pc_load_value = {r_hi, mem_rdata};
                flags_load    = 1'b1;
                flags_restore = r_flags_hold;
                if_flush      = 1'b1;
                w_next_state  = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign int_mem_selector1 = w_sel[1];
    assign int_mem_selector2 = w_sel[0];

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: entry, return, priority, ignored
// requests, mid-sequence reset, and a 1-cycle drain with a wrapping vector.
module tb_interrupt_controller;

    logic        clk;
    logic        reset;
    logic        int_req;
    logic        rti;
    logic [31:0] pc_current;
    logic [3:0]  flags;
    logic [15:0] mem_rdata;

    logic        stall, if_flush, sel1, sel2, pc_load, flags_load, busy, int_ack;
    logic [15:0] int_wdata, int_addr;
    logic [31:0] pc_load_value;
    logic [3:0]  flags_restore;
    logic [1:0]  sel;

    logic        b_int_req, b_rti;
    logic        b_stall, b_if_flush, b_sel1, b_sel2, b_pc_load, b_flags_load, b_busy, b_int_ack;
    logic [15:0] b_int_wdata, b_int_addr;
    logic [31:0] b_pc_load_value;
    logic [3:0]  b_flags_restore;
    logic [1:0]  b_sel;

    logic [78:0] all_out;

    int n_total = 0;
    int n_pass  = 0;

    assign sel     = {sel1, sel2};
    assign b_sel   = {b_sel1, b_sel2};
    assign all_out = {stall, if_flush, sel, int_wdata, int_addr, pc_load, pc_load_value,
                      flags_load, flags_restore, busy, int_ack};

    interrupt_controller #(.DRAIN_CYCLES(3), .VECTOR_ADDR(16'h0000)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .int_req           (int_req),
        .rti               (rti),
        .pc_current        (pc_current),
        .flags             (flags),
        .mem_rdata         (mem_rdata),
        .stall             (stall),
        .if_flush          (if_flush),
        .int_mem_selector1 (sel1),
        .int_mem_selector2 (sel2),
        .int_wdata         (int_wdata),
        .int_addr          (int_addr),
        .pc_load           (pc_load),
        .pc_load_value     (pc_load_value),
        .flags_load        (flags_load),
        .flags_restore     (flags_restore),
        .busy              (busy),
        .int_ack           (int_ack)
    );

    interrupt_controller #(.DRAIN_CYCLES(1), .VECTOR_ADDR(16'hFFFF)) u_dut_b (
        .clk               (clk),
        .reset             (reset),
        .int_req           (b_int_req),
        .rti               (b_rti),
        .pc_current        (pc_current),
        .flags             (flags),
        .mem_rdata         (mem_rdata),
        .stall             (b_stall),
        .if_flush          (b_if_flush),
        .int_mem_selector1 (b_sel1),
        .int_mem_selector2 (b_sel2),
        .int_wdata         (b_int_wdata),
        .int_addr          (b_int_addr),
        .pc_load           (b_pc_load),
        .pc_load_value     (b_pc_load_value),
        .flags_load        (b_flags_load),
        .flags_restore     (b_flags_restore),
        .busy              (b_busy),
        .int_ack           (b_int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance into the next cycle, present that cycle's memory read data, settle
    task automatic cyc(input logic [15:0] md);
        @(posedge clk);
        #1;
        mem_rdata = md;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(16'h0000);
        reset = 1'b1;
        cyc(16'h0000);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_total++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else n_pass++;
        n_total++;
        if ({b_busy, b_stall, b_sel} !== 4'b0) $display("FAIL reset_b_outputs: got %b want 0000", {b_busy, b_stall, b_sel});
        else n_pass++;
        cyc(16'h0000);
        reset = 1'b1;
        cyc(16'h0000);
        n_total++;
        if ({busy, stall} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {busy, stall});
        else n_pass++;
    endtask

    task automatic test_int_entry();
        pc_current = 32'h0001_0020;
        flags      = 4'b1010;
        int_req    = 1'b1;
        cyc(16'h0000);                                   // cycle 1: first DRAIN
        n_total++;
        if ({busy, stall, if_flush, sel} !== 5'b11100) $display("FAIL entry_drain1: got %b want 11100", {busy, stall, if_flush, sel});
        else n_pass++;
        int_req    = 1'b0;
        pc_current = 32'hDEAD_BEEF;
        flags      = 4'b0001;
        cyc(16'h0000);                                   // cycle 2
        n_total++;
        if ({busy, stall, if_flush, sel} !== 5'b11000) $display("FAIL entry_drain2: got %b want 11000", {busy, stall, if_flush, sel});
        else n_pass++;
        cyc(16'h0000);                                   // cycle 3
        cyc(16'h0000);                                   // cycle 4: PUSH_LO
        n_total++;
        if ({sel, int_wdata} !== {2'b10, 16'h0020}) $display("FAIL entry_push_lo: got %b/%h want 10/0020", sel, int_wdata);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 5: PUSH_HI
        n_total++;
        if ({sel, int_wdata} !== {2'b10, 16'h0001}) $display("FAIL entry_push_hi: got %b/%h want 10/0001", sel, int_wdata);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 6: PUSH_FL
        n_total++;
        if ({sel, int_wdata} !== {2'b10, 16'h000A}) $display("FAIL entry_push_fl: got %b/%h want 10/000a", sel, int_wdata);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 7: VEC_LO
        n_total++;
        if ({sel, int_addr} !== {2'b11, 16'h0000}) $display("FAIL entry_vec_lo: got %b/%h want 11/0000", sel, int_addr);
        else n_pass++;
        cyc(16'h0100);                                   // cycle 8: VEC_HI
        n_total++;
        if ({sel, int_addr} !== {2'b11, 16'h0001}) $display("FAIL entry_vec_hi: got %b/%h want 11/0001", sel, int_addr);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 9: JUMP
        n_total++;
        if ({pc_load, int_ack, if_flush, stall, sel} !== 6'b111100) $display("FAIL entry_jump_ctl: got %b want 111100", {pc_load, int_ack, if_flush, stall, sel});
        else n_pass++;
        n_total++;
        if (pc_load_value !== 32'h0000_0100) $display("FAIL entry_jump_pc: got %h want 00000100", pc_load_value);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 10: IDLE
        n_total++;
        if ({busy, stall, pc_load, int_ack} !== 4'b0000) $display("FAIL entry_idle: got %b want 0000", {busy, stall, pc_load, int_ack});
        else n_pass++;
    endtask

    task automatic test_rti();
        rti = 1'b1;
        cyc(16'h0000);                                   // cycle 1: first R_DRAIN
        n_total++;
        if ({busy, stall, if_flush, sel} !== 5'b11100) $display("FAIL rti_drain1: got %b want 11100", {busy, stall, if_flush, sel});
        else n_pass++;
        rti = 1'b0;
        cyc(16'h0000);
        cyc(16'h0000);
        cyc(16'h0000);                                   // cycle 4: POP_FL
        n_total++;
        if (sel !== 2'b01) $display("FAIL rti_pop_fl: got %b want 01", sel);
        else n_pass++;
        cyc(16'h000A);                                   // cycle 5: POP_HI
        cyc(16'h0001);                                   // cycle 6: POP_LO
        n_total++;
        if (sel !== 2'b01) $display("FAIL rti_pop_lo: got %b want 01", sel);
        else n_pass++;
        cyc(16'h0020);                                   // cycle 7: RESTORE
        n_total++;
        if ({pc_load, flags_load, if_flush, int_ack, sel} !== 6'b111000) $display("FAIL rti_restore_ctl: got %b want 111000", {pc_load, flags_load, if_flush, int_ack, sel});
        else n_pass++;
        n_total++;
        if (pc_load_value !== 32'h0001_0020) $display("FAIL rti_restore_pc: got %h want 00010020", pc_load_value);
        else n_pass++;
        n_total++;
        if (flags_restore !== 4'b1010) $display("FAIL rti_restore_flags: got %b want 1010", flags_restore);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 8: IDLE
        n_total++;
        if ({busy, pc_load, flags_load} !== 3'b000) $display("FAIL rti_idle: got %b want 000", {busy, pc_load, flags_load});
        else n_pass++;
    endtask

    task automatic test_priority();
        pc_current = 32'hCAFE_0000;
        flags      = 4'b0011;
        int_req    = 1'b1;
        rti        = 1'b1;
        cyc(16'h0000);                                   // cycle 1
        rti = 1'b0;
        cyc(16'h0000);
        cyc(16'h0000);
        cyc(16'h0000);                                   // cycle 4: must be POP_FL
        n_total++;
        if (sel !== 2'b01) $display("FAIL prio_rti_first: got %b want 01", sel);
        else n_pass++;
        cyc(16'h0005);
        cyc(16'h1234);
        cyc(16'h5678);                                   // cycle 7: RESTORE
        n_total++;
        if ({pc_load, flags_load, pc_load_value, flags_restore} !== {2'b11, 32'h1234_5678, 4'b0101})
            $display("FAIL prio_restore: got %b%b/%h/%b want 11/12345678/0101", pc_load, flags_load, pc_load_value, flags_restore);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 8: IDLE
        n_total++;
        if (busy !== 1'b0) $display("FAIL prio_idle_gap: got %b want 0", busy);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 9: DRAIN
        n_total++;
        if ({busy, if_flush, sel} !== 4'b1100) $display("FAIL prio_int_drain: got %b want 1100", {busy, if_flush, sel});
        else n_pass++;
        int_req = 1'b0;
        cyc(16'h0000);
        cyc(16'h0000);
        cyc(16'h0000);                                   // cycle 12: PUSH_LO
        n_total++;
        if ({sel, int_wdata} !== {2'b10, 16'h0000}) $display("FAIL prio_push_lo: got %b/%h want 10/0000", sel, int_wdata);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 13: PUSH_HI
        n_total++;
        if (int_wdata !== 16'hCAFE) $display("FAIL prio_push_hi: got %h want cafe", int_wdata);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 14: PUSH_FL
        n_total++;
        if (int_wdata !== 16'h0003) $display("FAIL prio_push_fl: got %h want 0003", int_wdata);
        else n_pass++;
        for (int i = 15; i <= 18; i++) cyc(16'h0000);    // VEC_LO, VEC_HI, JUMP, IDLE
        n_total++;
        if (busy !== 1'b0) $display("FAIL prio_final_idle: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_ignore();
        pc_current = 32'h0000_4444;
        flags      = 4'b0110;
        int_req    = 1'b1;
        cyc(16'h0000);                                   // cycle 1: DRAIN
        int_req = 1'b0;
        rti     = 1'b1;
        cyc(16'h0000);                                   // cycle 2: rti ignored
        rti = 1'b0;
        cyc(16'h0000);
        cyc(16'h0000);                                   // cycle 4: still entry path
        n_total++;
        if ({sel, int_wdata} !== {2'b10, 16'h4444}) $display("FAIL ign_push_lo: got %b/%h want 10/4444", sel, int_wdata);
        else n_pass++;
        cyc(16'h0000);
        cyc(16'h0000);                                   // cycle 6: PUSH_FL
        int_req = 1'b1;
        n_total++;
        if (int_wdata !== 16'h0006) $display("FAIL ign_push_fl: got %h want 0006", int_wdata);
        else n_pass++;
        cyc(16'h0000);                                   // cycle 7: VEC_LO
        int_req = 1'b0;
        cyc(16'h0000);
        cyc(16'h0000);                                   // cycle 9: JUMP
        n_total++;
        if (pc_load !== 1'b1) $display("FAIL ign_jump: got %b want 1", pc_load);
        else n_pass++;
        for (int i = 10; i <= 12; i++) begin
            cyc(16'h0000);
            n_total++;
            if ({busy, stall} !== 2'b00) $display("FAIL ign_stays_idle_c%0d: got %b want 00", i, {busy, stall});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        pc_current = 32'h0001_0020;
        flags      = 4'b1010;
        int_req    = 1'b1;
        cyc(16'h0000);
        int_req = 1'b0;
        for (int i = 2; i <= 5; i++) cyc(16'h0000);      // cycle 5: PUSH_HI
        n_total++;
        if ({sel, int_wdata} !== {2'b10, 16'h0001}) $display("FAIL rmid_push_hi: got %b/%h want 10/0001", sel, int_wdata);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (all_out !== '0) $display("FAIL rmid_async: got %h want 0", all_out);
        else n_pass++;
        cyc(16'h0000);
        n_total++;
        if ({busy, stall, sel, pc_load} !== 5'b0) $display("FAIL rmid_next: got %b want 00000", {busy, stall, sel, pc_load});
        else n_pass++;
        reset = 1'b1;
        cyc(16'h0000);
        cyc(16'h0000);
        n_total++;
        if (busy !== 1'b0) $display("FAIL rmid_no_restart: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_vector_wrap();
        pc_current = 32'h0000_1111;
        flags      = 4'b0000;
        b_int_req  = 1'b1;
        cyc(16'h0000);                                   // cycle 1: single DRAIN
        n_total++;
        if ({b_busy, b_if_flush, b_sel} !== 4'b1100) $display("FAIL wrap_drain: got %b want 1100", {b_busy, b_if_flush, b_sel});
        else n_pass++;
        b_int_req = 1'b0;
        cyc(16'h0000);                                   // cycle 2: PUSH_LO
        n_total++;
        if ({b_sel, b_int_wdata} !== {2'b10, 16'h1111}) $display("FAIL wrap_push_lo: got %b/%h want 10/1111", b_sel, b_int_wdata);
        else n_pass++;
        cyc(16'h0000);
        cyc(16'h0000);
        cyc(16'h0000);                                   // cycle 5: VEC_LO
        n_total++;
        if ({b_sel, b_int_addr} !== {2'b11, 16'hFFFF}) $display("FAIL wrap_vec_lo: got %b/%h want 11/ffff", b_sel, b_int_addr);
        else n_pass++;
        cyc(16'hBEEF);                                   // cycle 6: VEC_HI
        n_total++;
        if ({b_sel, b_int_addr} !== {2'b11, 16'h0000}) $display("FAIL wrap_vec_hi: got %b/%h want 11/0000", b_sel, b_int_addr);
        else n_pass++;
        cyc(16'h1234);                                   // cycle 7: JUMP
        n_total++;
        if ({b_pc_load, b_int_ack, b_pc_load_value} !== {2'b11, 32'h1234_BEEF})
            $display("FAIL wrap_jump: got %b%b/%h want 11/1234beef", b_pc_load, b_int_ack, b_pc_load_value);
        else n_pass++;
        cyc(16'h0000);
        n_total++;
        if (b_busy !== 1'b0) $display("FAIL wrap_idle: got %b want 0", b_busy);
        else n_pass++;
    endtask

    initial begin
        reset      = 1'b0;
        int_req    = 1'b0;
        rti        = 1'b0;
        b_int_req  = 1'b0;
        b_rti      = 1'b0;
        pc_current = '0;
        flags      = '0;
        mem_rdata  = '0;
        test_reset();
        test_int_entry();
        do_reset();
        test_rti();
        do_reset();
        test_priority();
        test_ignore();
        test_reset_mid();
        test_vector_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
